dcache_flush_ctrl: RTL and testbench
====================================

# dcache_flush_ctrl

Line-transfer controller for the data cache: the initiator side of the memblock's flush port. On a command it copies one cache line from the memblock to main memory (writeback), loads one line from main memory into the memblock (fill), or does both, in that order. It owns the memblock's flush_mode, flush_addr, flush_in and flush_we inputs and reads the memblock's data_out. It sits between the dcache tag/miss logic and the memory bus.

## Interface
- DATABITS, 32, word width; equals memblock data width
- ADDRBITS, 5, memblock word-address width
- LINEBITS, 2, log2 of words per line; LINEWORDS = 2**LINEBITS
- MEMADDRBITS, 30, memory word-address width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- do_wb  in  1  write the line back (valid with start)
- do_fill  in  1  fill the line (valid with start)
- line_idx  in  ADDRBITS-LINEBITS  cache line index
- wb_line  in  MEMADDRBITS-LINEBITS  memory line address for the writeback
- fill_line  in  MEMADDRBITS-LINEBITS  memory line address for the fill
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle completion pulse
- flush_mode  out  1  to memblock; high in all states except IDLE and DONE
- flush_addr  out  ADDRBITS  to memblock; {line_idx_q, word_cnt}; forced to 0 when flush_mode is low
- flush_in  out  DATABITS  to memblock; fill data register
- flush_we  out  1  to memblock; write strobe for all byte lanes
- cache_rdata  in  DATABITS  from memblock data_out; valid one cycle after flush_addr is presented
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  MEMADDRBITS  {line_q, word_cnt}
- mem_wdata  out  DATABITS  write data
- mem_ack  in  1  completes the current request
- mem_rdata  in  DATABITS  read data; valid in the mem_ack cycle

## Operation
- In IDLE, start=1 latches line_idx, wb_line, fill_line, do_wb and do_fill, and clears word_cnt.
  - do_wb=1: next state is WB_RD.
  - do_wb=0, do_fill=1: next state is FILL_REQ.
  - Both 0: next state is DONE.
- start is ignored outside IDLE.
- WB_RD: presents flush_addr for 1 cycle, then goes to WB_WR.
- WB_WR:
  - On entry, captures cache_rdata into the mem_wdata register.
  - Holds mem_req=1, mem_we=1 with stable address and data until mem_ack=1.
  - On ack: if word_cnt = LINEWORDS-1, word_cnt wraps to 0 and the next state is FILL_REQ (do_fill=1) or DONE; otherwise word_cnt increments and the next state is WB_RD.
- FILL_REQ: holds mem_req=1, mem_we=0 until mem_ack=1. On ack, latches mem_rdata into flush_in and goes to FILL_WR.
- FILL_WR: flush_we=1 for exactly 1 cycle at {line_idx_q, word_cnt}. Then either word_cnt increments and the next state is FILL_REQ, or, on the last word, the next state is DONE.
- DONE: done=1 and busy=1 for 1 cycle, then IDLE.
- mem_req is low in IDLE, WB_RD, FILL_WR and DONE. mem_ack arriving while mem_req is low is ignored.
- Reset values: state IDLE; all outputs 0; word_cnt 0; data registers 0.
- Reset mid-operation:
  - The controller returns to IDLE at once and mem_req drops.
  - A partly written line in the cache or in memory is left as is; recovery is the issuer's job.

## Timing
- Latency with zero-wait memory (mem_ack in the first req cycle):
  - 2 cycles per writeback word and 2 cycles per fill word.
  - With start in cycle 0 and LINEWORDS=4: wb+fill gives done in cycle 17; wb only or fill only gives done in cycle 9; neither gives done in cycle 1.
- Each memory wait cycle adds exactly 1 cycle.
- Back-to-back commands: start may be asserted in the cycle after done (IDLE), which gives a new busy in the following cycle.
- mem_req stays high across wait states. After an ack, the next request begins no earlier than 1 cycle later.

## Structure
- Shared package dcache_pkg:
  - state encoding: IDLE, WB_RD, WB_WR, FILL_REQ, FILL_WR, DONE
  - LINEWORDS derivation
  - memory-request field widths
- Single module. No sub-module is warranted: a word counter plus the state machine.

## Test plan
- Reset, then wb+fill on line 3 with zero-wait memory: memory writes go to {wb_line,0..3} with the 4 cache words; flush_we hits addresses 12..15 with the memory data; done is in cycle 17; flush_addr=0 and flush_mode=0 afterwards.
- Fill only, with 2 wait cycles on every ack: each word takes 4 cycles, done is in cycle 17, and mem_addr/mem_we stay stable through the waits.
- start with do_wb=0, do_fill=0: done pulses in cycle 1 with no mem_req and no flush_mode.
- start pulsed while busy: ignored, with no change to latched addresses or word count. A stray mem_ack in a WB_RD cycle is ignored.
- reset asserted during FILL_REQ of word 2: all outputs go to 0 immediately. A following command runs normally from word 0.
- Writeback of line 7 (last line, ADDRBITS=5): flush_addr runs 28..31 and word_cnt wraps cleanly to 0 at the end.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache line-transfer controller.
// Holds the controller state encoding, default geometry and width helpers.
// No logic; imported by the controller and anything that decodes its state.
package dcache_pkg;

    // Default geometry: word width, memblock word address, line size, memory word address
    localparam int DC_DATABITS    = 32;
    localparam int DC_ADDRBITS    = 5;
    localparam int DC_LINEBITS    = 2;
    localparam int DC_MEMADDRBITS = 30;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WB_RD    = 3'd1,
        ST_WB_WR    = 3'd2,
        ST_FILL_REQ = 3'd3,
        ST_FILL_WR  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Words per cache line
    function automatic int line_words(input int linebits);
        return 1 << linebits;
    endfunction

    // Width of a memory line address (memory word address minus the word-in-line bits)
    function automatic int mem_line_bits(input int memaddrbits, input int linebits);
        return memaddrbits - linebits;
    endfunction

    // Width of a cache line index
    function automatic int line_idx_bits(input int addrbits, input int linebits);
        return addrbits - linebits;
    endfunction

endpackage

// File: rtl/dcache_flush_ctrl.sv
// Copies one cache line memblock->memory (writeback), memory->memblock (fill), or both.
// Latency: 2 cycles per word per direction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: holds mem_req with stable address/data until mem_ack; start only taken in IDLE.
module dcache_flush_ctrl
    import dcache_pkg::*;
#(
    parameter int DATABITS    = DC_DATABITS,
    parameter int ADDRBITS    = DC_ADDRBITS,
    parameter int LINEBITS    = DC_LINEBITS,
    parameter int MEMADDRBITS = DC_MEMADDRBITS
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        do_wb,
    input  logic                                        do_fill,
    input  logic [line_idx_bits(ADDRBITS, LINEBITS)-1:0]    line_idx,
    input  logic [mem_line_bits(MEMADDRBITS, LINEBITS)-1:0] wb_line,
    input  logic [mem_line_bits(MEMADDRBITS, LINEBITS)-1:0] fill_line,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        flush_mode,
    output logic [ADDRBITS-1:0]                         flush_addr,
    output logic [DATABITS-1:0]                         flush_in,
    output logic                                        flush_we,
    input  logic [DATABITS-1:0]                         cache_rdata,
    output logic                                        mem_req,
    output logic                                        mem_we,
    output logic [MEMADDRBITS-1:0]                      mem_addr,
    output logic [DATABITS-1:0]                         mem_wdata,
    input  logic                                        mem_ack,
    input  logic [DATABITS-1:0]                         mem_rdata
);

    localparam int IDXBITS   = line_idx_bits(ADDRBITS, LINEBITS);
    localparam int MLBITS    = mem_line_bits(MEMADDRBITS, LINEBITS);
    localparam int LINEWORDS = line_words(LINEBITS);
    localparam logic [LINEBITS-1:0] LAST_WORD = LINEBITS'(LINEWORDS - 1);

    state_t                state, state_n;
    logic [LINEBITS-1:0]   word_cnt, word_cnt_n;
    logic [IDXBITS-1:0]    idx_q, idx_n;
    logic [MLBITS-1:0]     wb_line_q, wb_line_n;
    logic [MLBITS-1:0]     fill_line_q, fill_line_n;
    logic                  do_fill_q, do_fill_n;
    logic [DATABITS-1:0]   flush_in_n;
    logic                  mode_n;
    logic                  wr_first;
    logic [DATABITS-1:0]   wdata_q;

    // Next-state, word counter and command latch decisions
    always_comb begin
        state_n     = state;
        word_cnt_n  = word_cnt;
        idx_n       = idx_q;
        wb_line_n   = wb_line_q;
        fill_line_n = fill_line_q;
        do_fill_n   = do_fill_q;
        flush_in_n  = flush_in;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    idx_n       = line_idx;
                    wb_line_n   = wb_line;
                    fill_line_n = fill_line;
                    do_fill_n   = do_fill;
                    word_cnt_n  = '0;
                    if (do_wb)
                        state_n = ST_WB_RD;
                    else if (do_fill)
                        state_n = ST_FILL_REQ;
                    else
                        state_n = ST_DONE;
                end
            end
            // One cycle for the memblock read to come back
            ST_WB_RD: state_n = ST_WB_WR;
            ST_WB_WR: begin
                if (mem_ack) begin
                    word_cnt_n = word_cnt + LINEBITS'(1);
                    if (word_cnt == LAST_WORD)
                        state_n = do_fill_q ? ST_FILL_REQ : ST_DONE;
                    else
                        state_n = ST_WB_RD;
                end
            end
            ST_FILL_REQ: begin
                if (mem_ack) begin
                    flush_in_n = mem_rdata;
                    state_n    = ST_FILL_WR;
                end
            end
            ST_FILL_WR: begin
                word_cnt_n = word_cnt + LINEBITS'(1);
                state_n    = (word_cnt == LAST_WORD) ? ST_DONE : ST_FILL_REQ;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        mode_n = (state_n != ST_IDLE) && (state_n != ST_DONE);
    end

    // State, latches and registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            idx_q       <= '0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
            do_fill_q   <= 1'b0;
            wr_first    <= 1'b0;
            wdata_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            flush_mode  <= 1'b0;
            flush_addr  <= '0;
            flush_in    <= '0;
            flush_we    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            state       <= state_n;
            word_cnt    <= word_cnt_n;
            idx_q       <= idx_n;
            wb_line_q   <= wb_line_n;
            fill_line_q <= fill_line_n;
            do_fill_q   <= do_fill_n;
            flush_in    <= flush_in_n;
            busy        <= (state_n != ST_IDLE);
            done        <= (state_n == ST_DONE);
            flush_mode  <= mode_n;
            flush_addr  <= mode_n ? {idx_n, word_cnt_n} : '0;
            flush_we    <= (state_n == ST_FILL_WR);
            mem_req     <= (state_n == ST_WB_WR) || (state_n == ST_FILL_REQ);
            mem_we      <= (state_n == ST_WB_WR);
            if (state_n == ST_WB_WR)
                mem_addr <= {wb_line_n, word_cnt_n};
            else if (state_n == ST_FILL_REQ)
                mem_addr <= {fill_line_n, word_cnt_n};
            else
                mem_addr <= '0;
            // Marks the first WB_WR cycle, when the read data is on cache_rdata
            wr_first    <= (state_n == ST_WB_WR) && (state != ST_WB_WR);
            if (wr_first)
                wdata_q <= cache_rdata;
        end
    end

    // Read data is live only in the first WB_WR cycle; the captured copy holds it through waits
    assign mem_wdata = wr_first ? cache_rdata : wdata_q;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
module tb_dcache_flush_ctrl;
    localparam int DB = 32;
    localparam int AB = 5;
    localparam int LB = 2;
    localparam int MB = 30;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset, start, do_wb, do_fill;
    logic [2:0]    line_idx;
    logic [27:0]   wb_line, fill_line;
    logic          busy, done, flush_mode, flush_we, mem_req, mem_we, mem_ack;
    logic [AB-1:0] flush_addr;
    logic [DB-1:0] flush_in, cache_rdata, mem_wdata, mem_rdata;
    logic [MB-1:0] mem_addr;

    dcache_flush_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .do_wb(do_wb), .do_fill(do_fill),
        .line_idx(line_idx), .wb_line(wb_line), .fill_line(fill_line),
        .busy(busy), .done(done), .flush_mode(flush_mode), .flush_addr(flush_addr),
        .flush_in(flush_in), .flush_we(flush_we), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] data; } ev_t;
    ev_t exp_mw[$];
    ev_t exp_cw[$];
    int  exp_done[$];

    // Environment (memblock + memory) and the reference model's own copies
    logic [DB-1:0] cache_ram [0:31];
    logic [DB-1:0] main_ram  [logic [MB-1:0]];
    logic [DB-1:0] ref_cache [0:31];
    logic [DB-1:0] ref_mem   [logic [MB-1:0]];

    int mem_wait = 0;
    bit stray_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DB-1:0] dflt(input logic [MB-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction
    function automatic logic [DB-1:0] rd_main(input logic [MB-1:0] a);
        return main_ram.exists(a) ? main_ram[a] : dflt(a);
    endfunction
    function automatic logic [DB-1:0] rd_ref(input logic [MB-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memblock model: synchronous read, write on flush_we
    always @(posedge clk) begin
        cache_rdata <= cache_ram[flush_addr];
        if (flush_we) cache_ram[flush_addr] = flush_in;
    end

    // Memory responder: ack after mem_wait wait cycles; optional stray acks while idle
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_req) begin
                if (wcnt >= mem_wait) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                    if (mem_we) main_ram[mem_addr] = mem_wdata;
                    else        mem_rdata = rd_main(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops expected events whenever the DUT presents one
    initial begin
        logic          prev_hold, prev_we;
        logic [MB-1:0] prev_addr;
        logic [DB-1:0] prev_wd;
        ev_t           e;
        int            ed;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && mem_req) begin
                    chk("hold_addr", mem_addr, prev_addr);
                    chk("hold_we", mem_we, prev_we);
                    if (prev_we) chk("hold_wdata", mem_wdata, prev_wd);
                end
                prev_hold = mem_req && !mem_ack;
                prev_addr = mem_addr;
                prev_we   = mem_we;
                prev_wd   = mem_wdata;
                if (mem_req && mem_we && mem_ack) begin
                    checks++;
                    if (exp_mw.size() == 0) begin
                        fails++;
                        $display("FAIL mem_wr_unexpected: got write to %0h, expected none", mem_addr);
                    end else begin
                        checks--;
                        e = exp_mw.pop_front();
                        chk("mem_wr_addr", mem_addr, e.addr);
                        chk("mem_wr_data", mem_wdata, e.data);
                    end
                end
                if (flush_we) begin
                    checks++;
                    if (exp_cw.size() == 0) begin
                        fails++;
                        $display("FAIL cache_wr_unexpected: got write to %0d, expected none", flush_addr);
                    end else begin
                        checks--;
                        e = exp_cw.pop_front();
                        chk("cache_wr_addr", flush_addr, e.addr);
                        chk("cache_wr_data", flush_in, e.data);
                    end
                end
                if (done) begin
                    checks++;
                    if (exp_done.size() == 0) begin
                        fails++;
                        $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                    end else begin
                        checks--;
                        ed = exp_done.pop_front();
                        chk("done_cycle", cyc, ed);
                        chk("done_busy", busy, 1'b1);
                        chk("done_flush_mode", flush_mode, 1'b0);
                        chk("done_flush_addr", flush_addr, '0);
                        chk("done_mem_req", mem_req, 1'b0);
                    end
                end
            end
        end
    end

    task automatic scramble();
        do_wb = 1'($urandom); do_fill = 1'($urandom);
        line_idx = 3'($urandom); wb_line = 28'($urandom); fill_line = 28'($urandom);
    endtask

    // Issue one command at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after done
    task automatic run_cmd(input bit wb, input bit fl, input logic [2:0] idx,
                           input logic [27:0] wl, input logic [27:0] fll, input bit poke);
        int per, c0, n, act;
        logic [MB-1:0] a;
        logic [DB-1:0] d;
        per = 2 + mem_wait;
        c0  = cyc;
        act = 0;
        if (wb) for (int w = 0; w < LW; w++) begin
            a = {wl, 2'(w)};
            d = ref_cache[int'(idx) * LW + w];
            exp_mw.push_back('{32'(a), d});
            ref_mem[a] = d;
        end
        if (fl) for (int w = 0; w < LW; w++) begin
            d = rd_ref({fll, 2'(w)});
            exp_cw.push_back('{32'(int'(idx) * LW + w), d});
            ref_cache[int'(idx) * LW + w] = d;
        end
        exp_done.push_back(c0 + 1 + (wb ? LW * per : 0) + (fl ? LW * per : 0));
        start = 1'b1; do_wb = wb; do_fill = fl; line_idx = idx; wb_line = wl; fill_line = fll;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        chk("busy_after_start", busy, 1'b1);
        if (poke && (wb || fl)) begin
            @(posedge clk); #1;
            start = 1'b1; scramble();
            @(posedge clk); #1;
            start = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_req || flush_mode) act++;
        end while (!done && n < 600);
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", n);
        end
        if (!wb && !fl) chk("null_cmd_activity", act, 0);
        @(posedge clk); #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_flush_mode", flush_mode, 1'b0);
        chk("idle_flush_addr", flush_addr, '0);
        chk("mem_wr_left", exp_mw.size(), 0);
        chk("cache_wr_left", exp_cw.size(), 0);
        exp_mw.delete(); exp_cw.delete(); exp_done.delete();
    endtask

    initial begin
        int n, fw;
        logic [2:0]  ridx;
        logic [27:0] rwl, rfl;
        logic [DB-1:0] keep [0:3];
        for (int i = 0; i < 32; i++) begin
            cache_ram[i] = $urandom;
            ref_cache[i] = cache_ram[i];
        end
        reset = 1'b1; start = 1'b0; do_wb = 1'b0; do_fill = 1'b0;
        line_idx = '0; wb_line = '0; fill_line = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 1'b0);       chk("rst_done", done, 1'b0);
        chk("rst_flush_mode", flush_mode, 1'b0); chk("rst_flush_addr", flush_addr, '0);
        chk("rst_flush_in", flush_in, '0); chk("rst_flush_we", flush_we, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0); chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0); chk("rst_mem_wdata", mem_wdata, '0);

        // wb+fill, zero-wait, line 3
        mem_wait = 0;
        run_cmd(1, 1, 3'd3, 28'h0123456, 28'h0abcdef, 0);
        // fill only, 2 wait cycles per ack
        mem_wait = 2;
        run_cmd(0, 1, 3'd1, 28'h0, 28'h0000042, 0);
        // null command, back to back
        mem_wait = 0;
        run_cmd(0, 0, 3'd2, 28'h1, 28'h2, 0);
        // start pulsed while busy, stray acks while mem_req is low
        stray_en = 1;
        mem_wait = 1;
        run_cmd(1, 1, 3'd5, 28'h0000042, 28'h0123456, 1);
        stray_en = 0;

        // reset during the FILL_REQ of word 2
        mem_wait = 3;
        for (int w = 0; w < LW; w++) keep[w] = ref_cache[6 * LW + w];
        for (int w = 0; w < 2; w++) begin
            exp_cw.push_back('{32'(6 * LW + w), rd_ref({28'h0777777, 2'(w)})});
            keep[w] = rd_ref({28'h0777777, 2'(w)});
        end
        start = 1'b1; do_wb = 1'b0; do_fill = 1'b1; line_idx = 3'd6; fill_line = 28'h0777777;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; fw = 0;
        do begin
            @(negedge clk);
            n++;
            if (flush_we) fw++;
        end while (!(fw == 2 && mem_req && !flush_we) && n < 200);
        chk("reset_reached_word2", fw, 2);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);       chk("mid_rst_mem_req", mem_req, 1'b0);
        chk("mid_rst_flush_mode", flush_mode, 1'b0); chk("mid_rst_flush_addr", flush_addr, '0);
        chk("mid_rst_flush_in", flush_in, '0); chk("mid_rst_flush_we", flush_we, 1'b0);
        chk("mid_rst_mem_addr", mem_addr, '0); chk("mid_rst_mem_we", mem_we, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        exp_cw.delete(); exp_mw.delete(); exp_done.delete();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        for (int w = 0; w < LW; w++) begin
            chk("partial_line", cache_ram[6 * LW + w], keep[w]);
            ref_cache[6 * LW + w] = keep[w];
        end
        mem_wait = 0;
        run_cmd(0, 1, 3'd6, 28'h0, 28'h0000042, 0);

        // last line: flush_addr 28..31, then counter wrap into a fresh command
        run_cmd(1, 0, 3'd7, 28'h0fffff0, 28'h0, 0);
        run_cmd(1, 1, 3'd7, 28'h0000300, 28'h0fffff0, 0);

        // randomized commands
        for (int k = 0; k < 24; k++) begin
            mem_wait = $urandom_range(0, 2);
            stray_en = 1'($urandom);
            ridx = 3'($urandom);
            rwl  = 28'($urandom_range(0, 5));
            rfl  = ($urandom_range(0, 3) == 0) ? rwl : 28'($urandom_range(0, 5));
            run_cmd(1'($urandom), 1'($urandom), ridx, rwl, rfl, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
